dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store stage and the 16-bit word memory.
- It is the initiator side of the memory interface. It drives enable, wr, addr and data_in, and samples data_out.
- Read hits complete in the request cycle. Misses and all writes run a multi-cycle memory transaction while the CPU is stalled through cpu_ready.

Parameters:
- INDEX_WIDTH, 5, number of index bits; the cache holds 2**INDEX_WIDTH single-word lines.
- MEM_WAIT, 1, extra cycles the memory request is held before it completes; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- cpu_req  input  1  CPU access request; the CPU holds it and all cpu_* inputs stable until cpu_ready.
- cpu_wr  input  1  1 = store, 0 = load.
- cpu_addr  input  16  byte address; bit 0 is ignored.
- cpu_wdata  input  16  store data.
- cpu_rdata  output  16  load data; valid when cpu_ready=1 and cpu_wr=0.
- cpu_ready  output  1  access complete this cycle.
- mem_enable  output  1  memory enable.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  16  memory byte address (equals cpu_addr).
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data; combinational from mem_addr while mem_enable=1 and mem_wr=0.
- hit_count  output  16  read-hit counter; see Optional Feature.
- miss_count  output  16  read-miss counter; see Optional Feature.

Behaviour:
- Address split (word address = cpu_addr[15:1]):
  - index = cpu_addr[INDEX_WIDTH:1]
  - tag = cpu_addr[15:INDEX_WIDTH+1]
- Per line storage: valid bit, tag, 16-bit data.
- Reset (asynchronous):
  - state=IDLE, all valid bits=0, wait counter=0.
  - cpu_ready=0, cpu_rdata=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Tag and data arrays are not cleared.
  - Reset mid-transaction aborts it; no cache update occurs.
- IDLE:
  - No cpu_req: cpu_ready=0, memory outputs 0.
  - Read hit (valid and tag match): cpu_ready=1 combinationally in the same cycle, cpu_rdata = line data. Stay in IDLE.
  - Read miss: go to FILL, wait counter loaded with MEM_WAIT.
  - Write: if hit, update line data in this cycle (valid and tag unchanged); if miss, leave the line untouched. Go to WRITE, wait counter loaded with MEM_WAIT.
- FILL:
  - mem_enable=1, mem_wr=0, mem_addr=cpu_addr.
  - Counter decrements each cycle while nonzero.
  - On the cycle the counter is 0: write mem_rdata into the line (set valid, write tag, write data), latch it into a cpu_rdata register, go to DONE.
- WRITE:
  - mem_enable=1, mem_wr=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, held for MEM_WAIT+1 cycles.
  - After the last cycle go to DONE.
- DONE:
  - cpu_ready=1 for exactly one cycle, memory outputs 0.
  - cpu_rdata = latched fill data; for writes cpu_rdata=0.
  - Next state IDLE. A new request is sampled no earlier than the following cycle.
- Latency:
  - Read hit: 0 cycles (ready in the request cycle).
  - Read miss: MEM_WAIT+2 cycles from request to ready.
  - Write (hit or miss): MEM_WAIT+2 cycles.
- Outside FILL and WRITE: mem_enable=0 and mem_wr=0, so the memory drives 0 and no spurious write can occur.
- Back-to-back read hits sustain one per cycle.
- A write followed by a read to the same address returns the written data: from the cache if the write hit, otherwise via a miss fill from memory.
- cpu_req dropping mid-transaction is illegal. The FSM still completes; the bench need not cover it.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE read hit.
  - miss_count increments on entry to FILL.
  - Both are 16-bit, saturate at 0xFFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset with all inputs 0, release -> all outputs 0, state IDLE; first read of addr 0x0010 misses.
- MEM_WAIT=1, memory word 0x0010 preloaded with 0xBEEF, read 0x0010 -> mem_enable=1 for 2 cycles, cpu_ready on cycle 3, cpu_rdata=0xBEEF. Re-read -> cpu_ready in the same cycle with 0xBEEF, mem_enable stays 0.
- Write 0xA5A5 to 0x0010 after it is cached -> mem_wr=1 for 2 cycles with mem_wdata=0xA5A5. Subsequent read hits and returns 0xA5A5.
- Conflict: read 0x0010, then read 0x0050 (same index, INDEX_WIDTH=5) -> second is a miss. Reading 0x0010 again misses again.
- Write miss to 0x0100 with 0x1234 -> memory updated, line not allocated. A following read of 0x0100 misses and returns 0x1234.
- Assert rst during FILL cycle 1 -> outputs 0 immediately. After release, the same read misses. With DCACHE_STATS_EN: hit_count=0, miss_count=0 after reset, then 2 hits and 3 misses are counted correctly.

Source files
------------

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache controller that
//   sits between the CPU load/store stage and a 16-bit word memory. Each line
//   holds one 16-bit word plus its valid bit and tag.
//
//   Read hits complete combinationally in the request cycle. Read misses and
//   all writes run a memory transaction of MEM_WAIT+1 cycles followed by a
//   one-cycle DONE handshake, stalling the CPU through cpu_ready.
//
// Parameters
//   INDEX_WIDTH  index bits; 2**INDEX_WIDTH single-word lines
//   MEM_WAIT     extra cycles a memory request is held (0..15)
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata  CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready            load data / access-complete strobe
//   mem_enable/mem_wr/mem_addr/mem_wdata  memory request (registered)
//   mem_rdata                       memory read data (combinational)
//   hit_count, miss_count           read-hit / read-miss statistics
//
// Optional feature
//   DCACHE_STATS_EN  when defined, builds saturating 16-bit hit/miss counters;
//                    otherwise hit_count and miss_count are tied to zero.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int INDEX_WIDTH = 5,
    parameter int MEM_WAIT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int         DEPTH     = 1 << INDEX_WIDTH;
    localparam int         TAG_W     = 15 - INDEX_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [15:0]       data_mem [DEPTH];
    logic [15:0]       rdata_q;

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   idle_req;
    logic                   read_hit;
    logic                   read_miss;
    logic                   fill_done;

    assign index     = cpu_addr[INDEX_WIDTH:1];
    assign tag       = cpu_addr[15:INDEX_WIDTH+1];
    assign hit       = valid_q[index] && (tag_mem[index] == tag);
    assign idle_req  = (state == IDLE) && cpu_req;
    assign read_hit  = idle_req && !cpu_wr && hit;
    assign read_miss = idle_req && !cpu_wr && !hit;
    assign fill_done = (state == FILL) && (wait_cnt == 4'd0);

    // Hits answer straight from the array; DONE returns the latched fill data
    // (cleared to zero for writes).
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = 16'h0000;
        if (read_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[index];
        end else if (state == DONE) begin
            cpu_ready = 1'b1;
            cpu_rdata = rdata_q;
        end
    end

    // Control FSM; the memory request lines are registered and only ever
    // asserted while in FILL or WRITE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            valid_q    <= '0;
            rdata_q    <= 16'h0000;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_req && cpu_wr) begin
                        state      <= WRITE;
                        wait_cnt   <= WAIT_INIT;
                        rdata_q    <= 16'h0000;
                        mem_enable <= 1'b1;
                        mem_wr     <= 1'b1;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_wdata;
                    end else if (read_miss) begin
                        state      <= FILL;
                        wait_cnt   <= WAIT_INIT;
                        mem_enable <= 1'b1;
                        mem_addr   <= cpu_addr;
                    end
                end
                FILL, WRITE: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (state == FILL) begin
                            valid_q[index] <= 1'b1;
                            rdata_q        <= mem_rdata;
                        end
                        state      <= DONE;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        mem_addr   <= 16'h0000;
                        mem_wdata  <= 16'h0000;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage. Stale contents are harmless because valid_q gates
    // every hit, and a reset forces the FSM out of FILL before any update.
    // NOTE: the storage arrays have no reset; only the valid bits need one,
    // which keeps the arrays mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (idle_req && cpu_wr && hit) begin
            data_mem[index] <= cpu_wdata;
        end
        if (fill_done) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_rdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= 16'h0000;
            miss_q <= 16'h0000;
        end else begin
            if (read_hit && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if (read_miss && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
//   Directed bench for dcache_ctrl. A word memory model answers the DUT's
//   memory port. A reference model (reference memory plus a table of which
//   word address each cache line holds) predicts, per access, the cycle-by-
//   cycle handshake; one compare process checks the DUT against it on every
//   negative clock edge. Hand-computed latencies and data pin the model.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int IW    = 5;
    localparam int MW    = 1;
    localparam int LINES = 1 << IW;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_WIDTH(IW), .MEM_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Initial memory image: a few named words, a simple pattern elsewhere.
    function automatic logic [15:0] default_word(input logic [14:0] w);
        case (w)
            15'h0008: return 16'hBEEF;   // byte 0x0010
            15'h0028: return 16'h5050;   // byte 0x0050
            15'h0080: return 16'h0000;   // byte 0x0100
            default:  return {1'b0, w} ^ 16'h3C3C;
        endcase
    endfunction

    // Memory model: loads its image on the first edge, then services writes.
    logic [15:0] mem [0:32767];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32768; i++) mem[i] <= default_word(15'(i));
            mem_loaded <= 1'b1;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[15:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_enable && !mem_wr) ? mem[mem_addr[15:1]] : 16'h0000;

    // Reference model state.
    logic [15:0] ref_mem [0:32767];
    logic        m_valid [LINES];
    logic [14:0] m_word  [LINES];
    logic [15:0] m_data  [LINES];
    logic [15:0] exp_hits = 16'h0;
    logic [15:0] exp_misses = 16'h0;

    // Per-cycle expectations driven by the access tasks.
    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b0;
    logic [15:0] exp_rdata = 16'h0;
    logic        exp_en = 1'b0;
    logic        exp_wr = 1'b0;
    logic        exp_zero = 1'b0;
    logic [15:0] exp_addr = 16'h0;
    logic [15:0] exp_wdata = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
            if (exp_ready) check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
            check("mem_enable", 32'(mem_enable), 32'(exp_en));
            check("mem_wr", 32'(mem_wr), 32'(exp_wr));
            if (exp_en) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            if (exp_wr) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            if (exp_zero) begin
                check("mem_addr_idle", 32'(mem_addr), 32'd0);
                check("mem_wdata_idle", 32'(mem_wdata), 32'd0);
            end
            check("hit_count", 32'(hit_count), STATS ? 32'(exp_hits) : 32'd0);
            check("miss_count", 32'(miss_count), STATS ? 32'(exp_misses) : 32'd0);
        end
    end

    // One idle cycle with no request.
    task automatic idle();
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        exp_ready = 1'b0; exp_en = 1'b0; exp_wr = 1'b0; exp_zero = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // One CPU access, entered and left 1 time unit after a rising edge.
    // lat = request-to-ready cycles observed on the DUT (-1 if never ready).
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [15:0] rdata);
        logic [14:0] w;
        int          idx;
        logic        hit;
        int          n;
        w   = addr[15:1];
        idx = int'(w) % LINES;
        hit = m_valid[idx] && (m_word[idx] == w);
        n   = (!wr && hit) ? 1 : MW + 3;
        lat = -1;
        rdata = 16'h0;
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        for (int c = 0; c < n; c++) begin
            exp_ready = (c == n - 1);
            exp_rdata = wr ? 16'h0 : (hit ? m_data[idx] : ref_mem[w]);
            exp_en    = (n > 1) && (c >= 1) && (c <= MW + 1);
            exp_wr    = exp_en && wr;
            exp_addr  = addr;
            exp_wdata = wdata;
            exp_zero  = (n > 1) && (c == n - 1);
            @(negedge clk);
            if (cpu_ready && lat < 0) begin
                lat = c;
                rdata = cpu_rdata;
            end
            @(posedge clk); #1;
            if (c == 0 && !wr) begin
                if (hit && exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
                if (!hit && exp_misses != 16'hFFFF) exp_misses = exp_misses + 16'd1;
            end
        end
        if (wr) begin
            ref_mem[w] = wdata;
            if (hit) m_data[idx] = wdata;
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_word[idx]  = w;
            m_data[idx]  = ref_mem[w];
        end
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        exp_ready = 1'b0; exp_en = 1'b0; exp_wr = 1'b0; exp_zero = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_en"}, 32'(mem_enable), 32'd0);
        check({tag, "_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hits"}, 32'(hit_count), 32'd0);
        check({tag, "_misses"}, 32'(miss_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        for (int i = 0; i < 32768; i++) ref_mem[i] = default_word(15'(i));
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;

        // Reset with all inputs at zero.
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;
        idle(); idle();

        // Cold read miss: two memory cycles, ready on cycle 3.
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("miss_0010_lat", 32'(lat), 32'd3);
        check("miss_0010_data", 32'(rd), 32'hBEEF);
        // Re-read hits in the request cycle.
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("hit_0010_lat", 32'(lat), 32'd0);
        check("hit_0010_data", 32'(rd), 32'hBEEF);
        idle();

        // Write hit, then read back from the cache.
        access(1'b1, 16'h0010, 16'hA5A5, lat, rd);
        check("wr_hit_lat", 32'(lat), 32'd3);
        check("wr_hit_rdata", 32'(rd), 32'd0);
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("rd_after_wr_lat", 32'(lat), 32'd0);
        check("rd_after_wr_data", 32'(rd), 32'hA5A5);

        // Conflict on index 8: 0x0050 evicts 0x0010, which then misses again.
        access(1'b0, 16'h0050, 16'h0, lat, rd);
        check("conflict_lat", 32'(lat), 32'd3);
        check("conflict_data", 32'(rd), 32'h5050);
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("evicted_lat", 32'(lat), 32'd3);
        check("evicted_data", 32'(rd), 32'hA5A5);
        idle();

        // Write miss does not allocate; the read that follows fills from memory.
        access(1'b1, 16'h0100, 16'h1234, lat, rd);
        check("wr_miss_lat", 32'(lat), 32'd3);
        access(1'b0, 16'h0100, 16'h0, lat, rd);
        check("rd_after_wrmiss_lat", 32'(lat), 32'd3);
        check("rd_after_wrmiss_data", 32'(rd), 32'h1234);

        // Back-to-back hits, one per cycle.
        access(1'b0, 16'h0100, 16'h0, lat, rd);
        check("b2b_hit1_lat", 32'(lat), 32'd0);
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("b2b_hit2_lat", 32'(lat), 32'd0);
        check("b2b_hit2_data", 32'(rd), 32'hA5A5);
        idle();

        // Reset during the first FILL cycle aborts the fill.
        chk_en = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0050;
        @(posedge clk); #1;
        check("fill_started", 32'(mem_enable), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("midfill_rst");
        cpu_req = 1'b0; cpu_addr = 16'h0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_hits = 16'h0;
        exp_misses = 16'h0;
        chk_en = 1'b1;
        idle();

        // After reset: 3 misses and 2 hits.
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("post_rst_miss_lat", 32'(lat), 32'd3);
        check("post_rst_miss_data", 32'(rd), 32'hA5A5);
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("post_rst_hit1_lat", 32'(lat), 32'd0);
        access(1'b0, 16'h0010, 16'h0, lat, rd);
        check("post_rst_hit2_lat", 32'(lat), 32'd0);
        access(1'b0, 16'h0050, 16'h0, lat, rd);
        check("post_rst_0050_data", 32'(rd), 32'h5050);
        access(1'b0, 16'h0100, 16'h0, lat, rd);
        check("post_rst_0100_lat", 32'(lat), 32'd3);
        check("post_rst_0100_data", 32'(rd), 32'h1234);
        idle();
`ifdef DCACHE_STATS_EN
        check("stats_hits", 32'(hit_count), 32'd2);
        check("stats_misses", 32'(miss_count), 32'd3);
`else
        check("stats_hits_tied", 32'(hit_count), 32'd0);
        check("stats_misses_tied", 32'(miss_count), 32'd0);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
